// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC core: sequences the shared ALU, memory,
// IR, register file and PC, with a mem_ready handshake, run gating and an illegal-opcode trap.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_next_state;
  state_t           w_end_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      // Only reset leaves TRAP, so setting on entry is enough to make the flag sticky.
      if (w_next_state == S_TRAP) begin
        r_illegal <= 1'b1;
      end
      if ((r_state == S_FETCH) && mem_ready) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign w_end_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    w_next_state  = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (run) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      w_next_state = S_EXEC;
          OP_LW, OP_SW:  w_next_state = S_MEMADR;
          OP_BEQ:        w_next_state = S_BRANCH;
          OP_J:          w_next_state = S_JUMP;
          OP_ADDI:       w_next_state = S_ADDIEX;
          default:       w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_next_state = w_end_state;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next_state = w_end_state;
      end
      S_EXEC: begin
        alu_src_a    = 1'b1;
        aluop        = 2'b10;
        w_next_state = S_RWB;
      end
      S_RWB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        w_next_state = w_end_state;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_next_state  = w_end_state;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = 2'b10;
        w_next_state = w_end_state;
      end
      S_ADDIEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write    = 1'b1;
        w_next_state = w_end_state;
      end
      S_TRAP: begin
        w_next_state = S_TRAP;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign illegal     = r_illegal;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes the expected state,
// control word and retired count; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int CW = 6;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       rw;
    logic       m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       ill;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]    st;
    ctrl_t         ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_dst, reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0]    pc_source, alu_src_b, aluop;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  ctrl_t         obs_ctrl;

  exp_t          sb_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_checks = 0;
  int            n_errors = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
                     aluop, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:  begin c.mrd = 1'b1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      S_DECODE: begin c.asb = 2'b11; end
      S_MEMADR: begin c.asa = 1'b1; c.asb = 2'b10; end
      S_MEMRD:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.rw = 1'b1; c.m2r = 1'b1; end
      S_MEMWR:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.asa = 1'b1; c.aop = 2'b10; end
      S_RWB:    begin c.rw = 1'b1; c.rdst = 1'b1; end
      S_BRANCH: begin c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01; end
      S_JUMP:   begin c.pcw = 1'b1; c.pcs = 2'b10; end
      S_ADDIEX: begin c.asa = 1'b1; c.asb = 2'b10; end
      S_ADDIWB: begin c.rw = 1'b1; end
      S_TRAP:   begin c.ill = 1'b1; end
      default:  begin end
    endcase
    return c;
  endfunction

  // Called at a negedge: drive inputs, queue the expectation, advance one cycle.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st);
    exp_t e;
    run       = r;
    opcode    = op;
    mem_ready = rdy;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy);
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    if ((st == S_FETCH) && rdy) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'(obs_ctrl), 32'(e.ctrl));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = OP_R; mem_ready = 1'b0; exp_cnt = '0;
    #12;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_ctrl", 32'(obs_ctrl), 32'h0);
    check("rst_cnt", 32'(instr_count), 32'h0);

    run = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // R-type: 0,1,2,7,8 then back to FETCH
    cyc(1, OP_R, 1, S_IDLE);
    cyc(1, OP_R, 1, S_FETCH);
    cyc(1, OP_R, 1, S_DECODE);
    cyc(1, OP_R, 1, S_EXEC);
    cyc(1, OP_R, 1, S_RWB);

    // lw with two wait cycles: 7 cycles FETCH to FETCH
    cyc(1, OP_LW, 1, S_FETCH);
    cyc(1, OP_LW, 1, S_DECODE);
    cyc(1, OP_LW, 1, S_MEMADR);
    cyc(1, OP_LW, 0, S_MEMRD);
    cyc(1, OP_LW, 0, S_MEMRD);
    cyc(1, OP_LW, 1, S_MEMRD);
    cyc(1, OP_LW, 1, S_MEMWB);

    // sw with a fetch wait; run dropped during the wait must not abort the fetch
    cyc(0, OP_SW, 0, S_FETCH);
    cyc(0, OP_SW, 1, S_FETCH);
    cyc(0, OP_SW, 1, S_DECODE);
    cyc(1, OP_SW, 1, S_MEMADR);
    cyc(1, OP_SW, 0, S_MEMWR);
    cyc(1, OP_SW, 1, S_MEMWR);

    // beq then j
    cyc(1, OP_BEQ, 1, S_FETCH);
    cyc(1, OP_BEQ, 1, S_DECODE);
    cyc(1, OP_BEQ, 1, S_BRANCH);
    cyc(1, OP_J, 1, S_FETCH);
    cyc(1, OP_J, 1, S_DECODE);
    cyc(1, OP_J, 1, S_JUMP);

    // addi
    cyc(1, OP_ADDI, 1, S_FETCH);
    cyc(1, OP_ADDI, 1, S_DECODE);
    cyc(1, OP_ADDI, 1, S_ADDIEX);
    cyc(1, OP_ADDI, 1, S_ADDIWB);

    // run dropped during EXEC: RWB completes, then IDLE until run returns
    cyc(1, OP_R, 1, S_FETCH);
    cyc(1, OP_R, 1, S_DECODE);
    cyc(0, OP_R, 1, S_EXEC);
    cyc(0, OP_R, 1, S_RWB);
    cyc(0, OP_R, 1, S_IDLE);
    cyc(1, OP_R, 1, S_IDLE);

    // retired-count wrap using jumps
    for (int i = 0; (i < 70) && (exp_cnt != '1); i++) begin
      cyc(1, OP_J, 1, S_FETCH);
      cyc(1, OP_J, 1, S_DECODE);
      cyc(1, OP_J, 1, S_JUMP);
    end
    cyc(1, OP_J, 1, S_FETCH);
    cyc(1, OP_J, 1, S_DECODE);
    cyc(1, OP_J, 1, S_JUMP);
    #1;
    check("cnt_wrap", 32'(instr_count), 32'h0);

    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    cyc(1, OP_SW, 1, S_FETCH);
    cyc(1, OP_SW, 1, S_DECODE);
    cyc(1, OP_SW, 1, S_MEMADR);
    cyc(1, OP_SW, 0, S_MEMWR);
    #4;
    check("memwr_before_rst", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    check("memwr_async_rst", 32'(mem_write), 32'h0);
    check("state_async_rst", 32'(state), 32'(S_IDLE));
    check("ctrl_async_rst", 32'(obs_ctrl), 32'h0);
    check("cnt_async_rst", 32'(instr_count), 32'h0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // illegal opcode: TRAP holds for 20 cycles while run toggles
    cyc(1, OP_BAD, 1, S_IDLE);
    cyc(1, OP_BAD, 1, S_FETCH);
    cyc(1, OP_BAD, 1, S_DECODE);
    for (int i = 0; i < 20; i++) begin
      cyc(logic'(i % 2), OP_BAD, logic'((i % 3) == 0), S_TRAP);
    end
    #4;
    rst_n = 1'b0;
    #1;
    check("trap_rst_illegal", 32'(illegal), 32'h0);
    check("trap_rst_state", 32'(state), 32'(S_IDLE));
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, OP_R, 1, S_IDLE);
    cyc(1, OP_R, 1, S_IDLE);
    cyc(1, OP_R, 1, S_FETCH);
    cyc(0, OP_R, 1, S_DECODE);

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
